// File: rtl/bin_to_bcd_serial.sv
// Sequential binary-to-BCD converter (shift-and-add-3), emitting one BCD digit
// per valid/ready transfer, most significant digit first.
module bin_to_bcd_serial #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned DIGITS   = 3,
   parameter int unsigned LZ_BLANK = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] bin,
   output logic             ready,
   output logic             busy,
   output logic [3:0]       bcd,
   output logic             dig_valid,
   input  logic             dig_ready,
   output logic [3:0]       dig_idx,
   output logic             dig_last,
   output logic             done
);

   localparam int unsigned ACC_W = 4 * DIGITS;
   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      EMIT = 2'd2
   } state_t;

   state_t             state, state_n;
   logic [WIDTH-1:0]   sreg, sreg_n;
   logic [ACC_W-1:0]   acc, acc_n, acc_step;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic [3:0]         ptr, ptr_n, lead;
   logic               ready_n, busy_n, valid_n, done_n, last_n;
   logic [3:0]         bcd_n, idx_n;

   // One double-dabble iteration: correct every nibble >= 5, then shift in the next binary bit.
   function automatic logic [ACC_W-1:0] add3_shift(input logic [ACC_W-1:0] a, input logic b);
      logic [ACC_W-1:0] r;
      logic [3:0]       n;
      r = a;
      for (int i = 0; i < int'(DIGITS); i++) begin
         n = a[4*i +: 4];
         if (n >= 4'd5) n = n + 4'd3;
         r[4*i +: 4] = n;
      end
      return {r[ACC_W-2:0], b};
   endfunction

   // First digit to emit: the top digit, or the highest nonzero one when blanking.
   function automatic logic [3:0] lead_ptr(input logic [ACC_W-1:0] a);
      logic [3:0] p;
      p = 4'd0;
      if (LZ_BLANK == 0) begin
         p = 4'(DIGITS - 1);
      end else begin
         for (int i = 0; i < int'(DIGITS); i++) begin
            if (a[4*i +: 4] != 4'd0) p = 4'(i);
         end
      end
      return p;
   endfunction

   function automatic logic [3:0] nibble(input logic [ACC_W-1:0] a, input logic [3:0] p);
      return a[4*int'(p) +: 4];
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         sreg      <= '0;
         acc       <= '0;
         cnt       <= '0;
         ptr       <= '0;
         ready     <= 1'b1;
         busy      <= 1'b0;
         dig_valid <= 1'b0;
         done      <= 1'b0;
         bcd       <= 4'd0;
         dig_idx   <= 4'd0;
         dig_last  <= 1'b0;
      end else begin
         state     <= state_n;
         sreg      <= sreg_n;
         acc       <= acc_n;
         cnt       <= cnt_n;
         ptr       <= ptr_n;
         ready     <= ready_n;
         busy      <= busy_n;
         dig_valid <= valid_n;
         done      <= done_n;
         bcd       <= bcd_n;
         dig_idx   <= idx_n;
         dig_last  <= last_n;
      end
   end

   // Next state plus next values of every registered output.
   always_comb begin
      state_n  = state;
      sreg_n   = sreg;
      acc_n    = acc;
      cnt_n    = cnt;
      ptr_n    = ptr;
      ready_n  = ready;
      busy_n   = busy;
      valid_n  = dig_valid;
      done_n   = 1'b0;
      bcd_n    = bcd;
      idx_n    = dig_idx;
      last_n   = dig_last;
      acc_step = add3_shift(acc, sreg[WIDTH-1]);
      lead     = lead_ptr(acc_step);

      case (state)
         IDLE: begin
            if (start) begin
               state_n = CONV;
               sreg_n  = bin;
               acc_n   = '0;
               cnt_n   = CNT_W'(WIDTH);
               ready_n = 1'b0;
               busy_n  = 1'b1;
            end
         end
         CONV: begin
            sreg_n = sreg << 1;
            acc_n  = acc_step;
            cnt_n  = cnt - CNT_W'(1);
            // Last iteration: present the first digit straight from the final accumulator.
            if (cnt == CNT_W'(1)) begin
               state_n = EMIT;
               ptr_n   = lead;
               valid_n = 1'b1;
               bcd_n   = nibble(acc_step, lead);
               idx_n   = lead;
               last_n  = (lead == 4'd0);
            end
         end
         EMIT: begin
            if (dig_ready) begin
               if (ptr == 4'd0) begin
                  state_n = IDLE;
                  valid_n = 1'b0;
                  ready_n = 1'b1;
                  busy_n  = 1'b0;
                  done_n  = 1'b1;
                  bcd_n   = 4'd0;
                  idx_n   = 4'd0;
                  last_n  = 1'b0;
               end else begin
                  ptr_n  = ptr - 4'd1;
                  bcd_n  = nibble(acc, ptr - 4'd1);
                  idx_n  = ptr - 4'd1;
                  last_n = (ptr == 4'd1);
               end
            end
         end
         default: begin
            state_n = IDLE;
            ready_n = 1'b1;
            busy_n  = 1'b0;
            valid_n = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_bin_to_bcd_serial.sv
// Scoreboard bench for bin_to_bcd_serial: one instance without and one with leading-zero
// blanking, sharing stimulus; expected digits come from decimal arithmetic on the input.
module tb_bin_to_bcd_serial;

   localparam int unsigned WIDTH  = 8;
   localparam int unsigned DIGITS = 3;
   localparam bit PARAM_OK = (10 ** DIGITS) > (2 ** WIDTH - 1);

   typedef struct packed {
      logic [3:0] d;
      logic [3:0] idx;
      logic       last;
   } dig_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] bin;
   logic             dig_ready;
   logic             ready0, busy0, dv0, last0, done0;
   logic             ready1, busy1, dv1, last1, done1;
   logic [3:0]       bcd0, idx0, bcd1, idx1;

   int   n_chk = 0;
   int   n_fail = 0;
   int   rdy_mode = 0;
   dig_t q0[$];
   dig_t q1[$];
   logic pend[2], pv[2], pr[2], pl[2];
   logic [3:0] pb[2], pi[2];

   if (!PARAM_OK) begin : g_param_err
      initial $fatal(1, "FAIL params: 10^DIGITS must exceed 2^WIDTH-1");
   end

   bin_to_bcd_serial #(.WIDTH(WIDTH), .DIGITS(DIGITS), .LZ_BLANK(0)) dut0 (
      .clk(clk), .rst(rst), .start(start), .bin(bin), .ready(ready0), .busy(busy0),
      .bcd(bcd0), .dig_valid(dv0), .dig_ready(dig_ready), .dig_idx(idx0),
      .dig_last(last0), .done(done0));

   bin_to_bcd_serial #(.WIDTH(WIDTH), .DIGITS(DIGITS), .LZ_BLANK(1)) dut1 (
      .clk(clk), .rst(rst), .start(start), .bin(bin), .ready(ready1), .busy(busy1),
      .bcd(bcd1), .dig_valid(dv1), .dig_ready(dig_ready), .dig_idx(idx1),
      .dig_last(last1), .done(done1));

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: decimal digits by division; blanked stream starts at the highest nonzero digit.
   task automatic push_expected(input int v);
      int   val, n;
      int   dg[DIGITS];
      dig_t e;
      val = v;
      for (int i = 0; i < int'(DIGITS); i++) begin
         dg[i] = val % 10;
         val   = val / 10;
      end
      n = 1;
      for (int i = 0; i < int'(DIGITS); i++) if (dg[i] != 0) n = i + 1;
      for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
         e.d = 4'(dg[i]); e.idx = 4'(i); e.last = (i == 0);
         q0.push_back(e);
         if (i < n) q1.push_back(e);
      end
   endtask

   function automatic int qsize(input int k);
      return (k == 0) ? q0.size() : q1.size();
   endfunction

   function automatic dig_t qpop(input int k);
      return (k == 0) ? q0.pop_front() : q1.pop_front();
   endfunction

   task automatic mon(input int k, input logic dv, input logic [3:0] b, input logic [3:0] ix,
                      input logic ls, input logic dn);
      dig_t e;
      if (pend[k] || dn) chk($sformatf("done_pulse%0d", k), int'(dn), int'(pend[k]));
      if (pv[k] && !pr[k]) begin
         chk($sformatf("stall_valid%0d", k), int'(dv), 1);
         chk($sformatf("stall_bcd%0d", k), int'(b), int'(pb[k]));
         chk($sformatf("stall_idx%0d", k), int'(ix), int'(pi[k]));
         chk($sformatf("stall_last%0d", k), int'(ls), int'(pl[k]));
      end
      pend[k] = dv && dig_ready && ls;
      if (dv && dig_ready) begin
         if (qsize(k) == 0) begin
            chk($sformatf("extra_digit%0d", k), int'(b), -1);
         end else begin
            e = qpop(k);
            chk($sformatf("bcd%0d", k), int'(b), int'(e.d));
            chk($sformatf("dig_idx%0d", k), int'(ix), int'(e.idx));
            chk($sformatf("dig_last%0d", k), int'(ls), int'(e.last));
         end
      end
      pv[k] = dv; pr[k] = dig_ready; pb[k] = b; pi[k] = ix; pl[k] = ls;
   endtask

   // Monitor: consumes the scoreboard whenever a digit transfers.
   always @(negedge clk) begin
      if (rst) begin
         q0.delete();
         q1.delete();
         for (int k = 0; k < 2; k++) begin
            pend[k] = 1'b0; pv[k] = 1'b0; pr[k] = 1'b0;
         end
      end else begin
         mon(0, dv0, bcd0, idx0, last0, done0);
         mon(1, dv1, bcd1, idx1, last1, done1);
      end
   end

   // dig_ready driver: 0 = held high, 1 = toggling, 2 = random.
   initial begin
      dig_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       dig_ready = 1'b1;
            1:       dig_ready = ~dig_ready;
            default: dig_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   task automatic check_reset(input string tag);
      chk({tag, "_ready0"}, int'(ready0), 1);  chk({tag, "_ready1"}, int'(ready1), 1);
      chk({tag, "_busy0"}, int'(busy0), 0);    chk({tag, "_busy1"}, int'(busy1), 0);
      chk({tag, "_valid0"}, int'(dv0), 0);     chk({tag, "_valid1"}, int'(dv1), 0);
      chk({tag, "_done0"}, int'(done0), 0);    chk({tag, "_done1"}, int'(done1), 0);
      chk({tag, "_bcd0"}, int'(bcd0), 0);      chk({tag, "_bcd1"}, int'(bcd1), 0);
      chk({tag, "_idx0"}, int'(idx0), 0);      chk({tag, "_idx1"}, int'(idx1), 0);
      chk({tag, "_last0"}, int'(last0), 0);    chk({tag, "_last1"}, int'(last1), 0);
   endtask

   task automatic wait_idle();
      int k = 0;
      while (!(ready0 && ready1) && k < 200) begin
         @(posedge clk);
         #1;
         k++;
      end
      if (k >= 200) chk("idle_timeout", 0, 1);
   endtask

   task automatic issue(input int v);
      bin   = WIDTH'(v);
      start = 1'b1;
      push_expected(v);
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic apply_reset(input string tag);
      rst = 1'b1;
      #1;
      check_reset(tag);
      @(negedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      int k;
      rst   = 1'b1;
      start = 1'b0;
      bin   = '0;
      repeat (2) @(posedge clk);
      #1;
      check_reset("reset");
      rst = 1'b0;
      @(posedge clk);
      #1;

      // 255 with ready held high: acceptance response and latency to first digit.
      issue(255);
      chk("accept_busy", int'(busy0), 1);
      chk("accept_ready", int'(ready0), 0);
      k = 0;
      while (!dv0 && k < 50) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk("first_digit_latency", k, int'(WIDTH));
      wait_idle();

      // Zero, and blanking around interior zeros.
      issue(0);   wait_idle();
      issue(100); wait_idle();
      issue(7);   wait_idle();

      // Toggling ready must stall without loss or duplication.
      rdy_mode = 1;
      issue(209); wait_idle();
      rdy_mode = 0;
      @(posedge clk);
      #1;

      // start during CONV is ignored; start in the done cycle is accepted.
      issue(123);
      repeat (2) @(posedge clk);
      #1;
      bin   = WIDTH'(99);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      k = 0;
      while (!done0 && k < 50) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk("done_seen", int'(done0), 1);
      chk("done_cycle_ready", int'(ready0), 1);
      chk("done_cycle_busy", int'(busy0), 0);
      issue(45);
      chk("b2b_accepted", int'(busy0), 1);
      wait_idle();

      // Reset mid-CONV, then reset after the first digit transfers.
      issue(187);
      repeat (3) @(posedge clk);
      #1;
      apply_reset("rst_conv");
      issue(234);
      k = 0;
      while (!dv0 && k < 50) begin
         @(posedge clk);
         #1;
         k++;
      end
      @(posedge clk);
      #1;
      apply_reset("rst_emit");
      issue(58);
      wait_idle();

      // Randomized values under random backpressure.
      for (int i = 0; i < 40; i++) begin
         rdy_mode = int'($urandom_range(0, 2));
         wait_idle();
         issue(int'($urandom_range(0, 2 ** WIDTH - 1)));
      end
      rdy_mode = 0;
      wait_idle();
      repeat (3) @(posedge clk);
      #1;
      chk("queue0_drained", q0.size(), 0);
      chk("queue1_drained", q1.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
